// File: rtl/tt_count_sched_pkg.sv
// tt_count_sched_pkg
//   Shared definitions for the tt_count_sched block: FSM state type,
//   default parameter values and a helper for index widths.
package tt_count_sched_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of an index into n requesters (at least 1 bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_count_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans req starting at index ptr,
//   wrapping modulo NREQ, and reports the first set requester.
// Ports
//   req         in   NREQ  request vector
//   ptr         in   PW    index to start scanning from
//   win_onehot  out  NREQ  one-hot winner (0 when no request)
//   win_idx     out  PW    winner index (0 when no request)
//   any         out  1     at least one request is set
module rr_pick
    import tt_count_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    always_comb begin
        logic [PW-1:0] cand;
        cand       = '0;
        win_onehot = '0;
        win_idx    = '0;
        any        = |req;
        // Scan from the farthest offset back to ptr so the closest set
        // request (in round-robin order) is the last one to overwrite.
        for (int unsigned j = NREQ; j > 0; j--) begin
            cand = PW'((32'(ptr) + j - 1) % NREQ);
            if (req[cand]) begin
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/tt_count_sched.sv
// tt_count_sched
//   Round-robin scheduler sharing one down-counter between NREQ requesters.
//   A granted requester gets len+1 cycles (count_out len..0) unless it drops
//   its request early; every grant ends with a 1-cycle done pulse, with
//   aborted marking a withdrawal.
// Ports
//   clk        in   1        clock, posedge
//   rst_n      in   1        synchronous reset, active-low
//   req        in   NREQ     per-requester level request
//   len_in     in   NREQ*CW  packed lengths, requester i at [i*CW +: CW]
//   gnt        out  NREQ     one-hot grant, registered
//   busy       out  1        high while in RUN
//   done       out  1        1-cycle pulse at the end of each grant
//   aborted    out  1        qualifies done: grant ended by withdrawal
//   count_out  out  CW       current counter value
module tt_count_sched
    import tt_count_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned CW   = CW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len_in,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CW-1:0]    count_out
);

    localparam int unsigned   PW       = ptr_width(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   widx_q, widx_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic [PW-1:0]   ptr_after_win;
    logic [CW-1:0]   len_arr [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            len_arr[i] = len_in[i*CW +: CW];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    assign ptr_after_win = (widx_q == LAST_IDX) ? '0 : widx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            widx_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Outputs are registered: the next-cycle values are computed here so
    // that done/aborted are visible during the DONE state itself.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_d   = '0;
                count_d = '0;
                if (win_any) begin
                    state_d = S_RUN;
                    gnt_d   = win_onehot;
                    count_d = len_arr[win_idx];
                    widx_d  = win_idx;
                end
            end
            S_RUN: begin
                // Withdrawal wins over reaching zero; the count is frozen
                // on the ending cycle and shown during DONE.
                if (!req[widx_q] || count_q == '0) begin
                    state_d = S_DONE;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    abort_d = !req[widx_q];
                    ptr_d   = ptr_after_win;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign aborted   = abort_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_tt_count_sched.sv
// Testbench for tt_count_sched (NREQ=4, CW=4): directed scenarios with
// literal expectations plus a per-cycle comparison against a grant-level
// model of the scheduler.
module tb_tt_count_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] len_in;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  count_out;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    tt_count_sched #(
        .NREQ (4),
        .CW   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .len_in    (len_in),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- grant-level model ----------------
    // phase: 0 waiting for a pick, 1 interval in progress, 2 completion cycle
    int         m_phase = 0;
    int         m_w     = 0;
    int         m_cnt   = 0;
    int         m_ptr   = 0;
    bit         m_done  = 0;
    bit         m_ab    = 0;
    logic [3:0] m_gnt   = '0;

    function automatic int rr_first(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        if (!rst_n) begin
            m_phase <= 0; m_w <= 0; m_cnt <= 0; m_ptr <= 0;
            m_done <= 0; m_ab <= 0; m_gnt <= '0;
        end else begin
            m_done <= 0;
            m_ab   <= 0;
            case (m_phase)
                0: begin
                    w = rr_first(req, m_ptr);
                    if (w >= 0) begin
                        m_phase <= 1;
                        m_w     <= w;
                        m_gnt   <= 4'(1 << w);
                        m_cnt   <= int'((len_in >> (4 * w)) & 16'hF);
                    end else begin
                        m_gnt <= '0;
                        m_cnt <= 0;
                    end
                end
                1: begin
                    if (!req[m_w] || m_cnt == 0) begin
                        m_phase <= 2;
                        m_gnt   <= '0;
                        m_done  <= 1;
                        m_ab    <= !req[m_w];
                        m_ptr   <= (m_w + 1) % 4;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    m_phase <= 0;
                    m_gnt   <= '0;
                    m_cnt   <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_busy", 32'(busy), 32'(m_phase == 1));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_aborted", 32'(aborted), 32'(m_ab));
            chk("model_count", 32'(count_out), 32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_seq [5];
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

        rst_n = 1'b0; req = '0; len_in = '0;
        tick(2);
        cmp_en = 1'b1;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_count", 32'(count_out), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_gnt", 32'(gnt), 0);

        // 1: single requester, len=3
        len_in = {4'd0, 4'd0, 4'd0, 4'd3};
        req    = 4'b0001;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_gnt", 32'(gnt), 32'h1);
            chk("t1_count", 32'(count_out), 32'(3 - k));
            tick(1);
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_aborted", 32'(aborted), 0);
        chk("t1_gnt_off", 32'(gnt), 0);
        req = '0;
        tick(1);

        // 2: all requesting, len=0, round-robin from ptr 0
        rst_n = 1'b0;
        tick(1);
        rst_n  = 1'b1;
        len_in = '0;
        req    = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            chk("t2_gnt", 32'(gnt), 32'(rr_seq[k]));
            chk("t2_count", 32'(count_out), 0);
            tick(1);
            chk("t2_done", 32'(done), 1);
            chk("t2_gnt_off", 32'(gnt), 0);
            tick(2);
        end
        req = '0;
        tick(2);

        // 3: withdrawal during RUN
        len_in = {4'd0, 4'd9, 4'd0, 4'd0};
        req    = 4'b0100;
        tick(1);
        chk("t3_gnt", 32'(gnt), 32'h4);
        chk("t3_count9", 32'(count_out), 9);
        tick(1);
        chk("t3_count8", 32'(count_out), 8);
        tick(1);
        chk("t3_count7", 32'(count_out), 7);
        req = '0;
        tick(1);
        chk("t3_done", 32'(done), 1);
        chk("t3_aborted", 32'(aborted), 1);
        chk("t3_count_hold", 32'(count_out), 7);
        tick(1);
        chk("t3_aborted_clear", 32'(aborted), 0);

        // 6: grant to 3 then pointer wraps to 0
        len_in = {4'd1, 4'd0, 4'd0, 4'd2};
        req    = 4'b1000;
        tick(1);
        chk("t6_gnt3", 32'(gnt), 32'h8);
        tick(2);
        chk("t6_done", 32'(done), 1);
        req = 4'b1001;
        tick(1);
        chk("t6_idle_gnt", 32'(gnt), 0);
        tick(1);
        chk("t6_wrap_gnt", 32'(gnt), 32'h1);
        chk("t6_wrap_count", 32'(count_out), 2);
        req = '0;
        tick(2);

        // 4: reset mid-grant
        len_in = {4'd0, 4'd0, 4'd7, 4'd0};
        req    = 4'b0010;
        tick(3);
        chk("t4_gnt", 32'(gnt), 32'h2);
        chk("t4_count", 32'(count_out), 5);
        rst_n = 1'b0;
        tick(1);
        chk("t4_rst_gnt", 32'(gnt), 0);
        chk("t4_rst_count", 32'(count_out), 0);
        chk("t4_rst_done", 32'(done), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        req   = 4'b1010;
        tick(1);
        chk("t4_after_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick(2);

        // 5: max length, no wrap, len_in change mid-RUN ignored
        len_in = {4'd0, 4'd0, 4'd0, 4'd15};
        req    = 4'b0001;
        tick(1);
        for (int k = 0; k < 16; k++) begin
            chk("t5_gnt", 32'(gnt), 32'h1);
            chk("t5_count", 32'(count_out), 32'(15 - k));
            if (k == 5) len_in = 16'h3333;
            tick(1);
        end
        chk("t5_done", 32'(done), 1);
        chk("t5_aborted", 32'(aborted), 0);
        chk("t5_count_final", 32'(count_out), 0);
        req = '0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
